// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int WORD_W = 64;
    localparam int OFS_W  = 3;
    localparam int CNT_W  = 4;

    function automatic logic addr_misaligned(input logic [OFS_W-1:0] ofs);
        return (ofs != {OFS_W{1'b0}});
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// DEPTH x 64 storage with one synchronous write port and one synchronous read port; no reset.
module dmem_responder_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              CLK,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage write and registered read, both only on a commit edge.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus responder: accept, programmable wait, one-cycle MemReady response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        MemReady,
    output logic        MemError
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_e            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [63:0]       addr_r, wdata_r;
    logic              rd_r, wr_r;
    logic              ready_r, err_r, rd_valid_r;

    logic              req_s, commit_s, err_s, we_s, re_s;
    logic              cur_rd_s, cur_wr_s;
    logic [63:0]       cur_addr_s, cur_wdata_s, diff_s;
    logic [AW-1:0]     idx_s;
    logic [WORD_W-1:0] rdata_s;

    // With zero latency the commit happens on the accept edge, so decode live inputs in IDLE.
    always_comb begin
        req_s = MemoryRead | MemoryWrite;
        if (state_r == ST_IDLE) begin
            cur_addr_s  = Address;
            cur_wdata_s = WriteData;
            cur_rd_s    = MemoryRead;
            cur_wr_s    = MemoryWrite;
        end else begin
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
            cur_rd_s    = rd_r;
            cur_wr_s    = wr_r;
        end
        diff_s = cur_addr_s - BASE_ADDR;
        idx_s  = diff_s[OFS_W +: AW];
        err_s  = addr_misaligned(diff_s[OFS_W-1:0])
               | (cur_addr_s < BASE_ADDR)
               | ((diff_s >> (OFS_W + AW)) != 64'd0)
               | (cur_rd_s & cur_wr_s);
    end

    // Next-state logic; commit_s marks the edge entering RESP.
    always_comb begin
        state_nxt_s = state_r;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (LATENCY == 0) begin
                        state_nxt_s = ST_RESP;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RESP;
                    commit_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
        // A reset coinciding with the commit edge must suppress the array access.
        we_s = commit_s & ~err_s & cur_wr_s & ~reset;
        re_s = commit_s & ~err_s & cur_rd_s & ~reset;
    end

    // FSM state, wait counter, request latches and response registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= 64'd0;
            wdata_r    <= 64'd0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= commit_s;
            if (state_r == ST_IDLE && req_s) begin
                addr_r  <= Address;
                wdata_r <= WriteData;
                rd_r    <= MemoryRead;
                wr_r    <= MemoryWrite;
                cnt_r   <= LAT_M1;
            end else if (state_r == ST_WAIT && cnt_r != {CNT_W{1'b0}}) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (commit_s) begin
                err_r      <= err_s;
                rd_valid_r <= cur_rd_s & ~err_s;
            end
        end
    end

    dmem_responder_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .CLK   (CLK),
        .we    (we_s),
        .re    (re_s),
        .idx   (idx_s),
        .wdata (cur_wdata_s),
        .rdata (rdata_s)
    );

    assign MemReady = ready_r;
    assign MemError = err_r;
    assign ReadData = rd_valid_r ? rdata_s : 64'd0;

endmodule
